// File: rtl/estagio_id_ex.sv
// estagio_id_ex: ID/EX skid register feeding the 8-bit ALU with writeback forwarding.
// Ports: Clock/Reset (sync, active-low); decode side EntValida/EntPronta/EntULAOp/EntRegA/EntRegB/
//   EntDadoA/EntDadoB/EntImediato/EntUsaImed; writeback EscWB/RegWB/DadoWB; Flush;
//   ALU side SaiValida/SaiPronta/ULAOp/Dado1/Dado2; sticky OpInvalida.
module estagio_id_ex #(
  parameter int LARGURA   = 8,
  parameter int NREG_BITS = 2
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 EntValida,
  output logic                 EntPronta,
  input  logic [1:0]           EntULAOp,
  input  logic [NREG_BITS-1:0] EntRegA,
  input  logic [NREG_BITS-1:0] EntRegB,
  input  logic [LARGURA-1:0]   EntDadoA,
  input  logic [LARGURA-1:0]   EntDadoB,
  input  logic [LARGURA-1:0]   EntImediato,
  input  logic                 EntUsaImed,
  input  logic                 EscWB,
  input  logic [NREG_BITS-1:0] RegWB,
  input  logic [LARGURA-1:0]   DadoWB,
  input  logic                 Flush,
  output logic                 SaiValida,
  input  logic                 SaiPronta,
  output logic [1:0]           ULAOp,
  output logic [LARGURA-1:0]   Dado1,
  output logic [LARGURA-1:0]   Dado2,
  output logic                 OpInvalida
);
  typedef struct packed {
    logic [1:0]           op;
    logic [LARGURA-1:0]   a;
    logic [LARGURA-1:0]   b;
    logic [NREG_BITS-1:0] ra;
    logic [NREG_BITS-1:0] rb;
    logic                 ui;
  } ent_t;
  ent_t m, s, m_fwd, s_fwd, ent_in;
  logic m_valid, s_valid, accept, consume;
  assign EntPronta = Reset & ~s_valid;
  assign accept    = EntValida & EntPronta;
  assign consume   = m_valid & SaiPronta;
  assign SaiValida = m_valid;
  assign ULAOp     = m.op;
  assign Dado1     = m.a;
  assign Dado2     = m.b;
  // Held entries keep their source registers so a later writeback can still refresh them;
  // an immediate operand 2 is never a register value and must not be overwritten.
  always_comb begin
    m_fwd    = m;
    m_fwd.a  = (EscWB && RegWB == m.ra) ? DadoWB : m.a;
    m_fwd.b  = (EscWB && !m.ui && RegWB == m.rb) ? DadoWB : m.b;
    s_fwd    = s;
    s_fwd.a  = (EscWB && RegWB == s.ra) ? DadoWB : s.a;
    s_fwd.b  = (EscWB && !s.ui && RegWB == s.rb) ? DadoWB : s.b;
    ent_in.op = EntULAOp;
    ent_in.ra = EntRegA;
    ent_in.rb = EntRegB;
    ent_in.ui = EntUsaImed;
    ent_in.a  = (EscWB && RegWB == EntRegA) ? DadoWB : EntDadoA;
    ent_in.b  = EntUsaImed ? EntImediato : ((EscWB && RegWB == EntRegB) ? DadoWB : EntDadoB);
  end
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      m          <= '0;
      s          <= '0;
      m_valid    <= 1'b0;
      s_valid    <= 1'b0;
      OpInvalida <= 1'b0;
    end else if (Flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (!m_valid || consume) begin
      // Main register is free this edge: the skid entry has priority over new input,
      // and EntPronta is already low whenever the skid is full.
      if (s_valid) begin
        m          <= s_fwd;
        m_valid    <= 1'b1;
        s_valid    <= 1'b0;
        OpInvalida <= OpInvalida | (s.op == 2'b11);
      end else if (accept) begin
        m          <= ent_in;
        m_valid    <= 1'b1;
        OpInvalida <= OpInvalida | (EntULAOp == 2'b11);
      end else begin
        m_valid <= 1'b0;
      end
    end else begin
      m <= m_fwd;
      if (s_valid) s <= s_fwd;
      if (accept) begin
        s       <= ent_in;
        s_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_estagio_id_ex.sv
// tb_estagio_id_ex: directed self-checking bench for estagio_id_ex.
module tb_estagio_id_ex;
  logic       Clock = 1'b0;
  logic       Reset, EntValida, EntPronta, EntUsaImed, EscWB, Flush, SaiValida, SaiPronta, OpInvalida;
  logic [1:0] EntULAOp, EntRegA, EntRegB, RegWB, ULAOp;
  logic [7:0] EntDadoA, EntDadoB, EntImediato, DadoWB, Dado1, Dado2;
  int errors = 0;
  int checks = 0;

  estagio_id_ex dut (
    .Clock(Clock), .Reset(Reset), .EntValida(EntValida), .EntPronta(EntPronta),
    .EntULAOp(EntULAOp), .EntRegA(EntRegA), .EntRegB(EntRegB), .EntDadoA(EntDadoA),
    .EntDadoB(EntDadoB), .EntImediato(EntImediato), .EntUsaImed(EntUsaImed),
    .EscWB(EscWB), .RegWB(RegWB), .DadoWB(DadoWB), .Flush(Flush),
    .SaiValida(SaiValida), .SaiPronta(SaiPronta), .ULAOp(ULAOp),
    .Dado1(Dado1), .Dado2(Dado2), .OpInvalida(OpInvalida)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [1:0] ra, input logic [1:0] rb,
                       input logic [7:0] da, input logic [7:0] db, input logic ui, input logic [7:0] imm);
    EntValida = 1'b1; EntULAOp = op; EntRegA = ra; EntRegB = rb;
    EntDadoA = da; EntDadoB = db; EntUsaImed = ui; EntImediato = imm;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    tick();
    checks++; if (SaiValida !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", SaiValida); end
    checks++; if (EntPronta !== 1'b0) begin errors++; $display("FAIL reset_pronta got=%b exp=0", EntPronta); end
    checks++; if ({ULAOp, Dado1, Dado2} !== 18'h0) begin errors++; $display("FAIL reset_data got=%h/%h/%h exp=0/0/0", ULAOp, Dado1, Dado2); end
    checks++; if (OpInvalida !== 1'b0) begin errors++; $display("FAIL reset_opinv got=%b exp=0", OpInvalida); end
    Reset = 1'b1;
    #1;
    checks++; if (EntPronta !== 1'b1) begin errors++; $display("FAIL post_reset_pronta got=%b exp=1", EntPronta); end
  endtask

  task automatic test_basic();
    SaiPronta = 1'b1;
    drive(2'b00, 2'd0, 2'd1, 8'd3, 8'd4, 1'b0, 8'h00);
    tick();
    EntValida = 1'b0;
    checks++; if ({SaiValida, ULAOp, Dado1, Dado2} !== {1'b1, 2'b00, 8'd3, 8'd4}) begin errors++;
      $display("FAIL basic got=%b/%b/%0d/%0d exp=1/00/3/4", SaiValida, ULAOp, Dado1, Dado2); end
    tick();
    checks++; if (SaiValida !== 1'b0) begin errors++; $display("FAIL basic_drain got=%b exp=0", SaiValida); end
  endtask

  task automatic test_back_to_back();
    SaiPronta = 1'b0;
    drive(2'b01, 2'd0, 2'd1, 8'd5, 8'd6, 1'b0, 8'h00);
    tick();
    checks++; if (EntPronta !== 1'b1) begin errors++; $display("FAIL b2b_pronta1 got=%b exp=1", EntPronta); end
    drive(2'b10, 2'd0, 2'd1, 8'd7, 8'd8, 1'b0, 8'h00);
    tick();
    EntValida = 1'b0;
    checks++; if (EntPronta !== 1'b0) begin errors++; $display("FAIL b2b_pronta2 got=%b exp=0", EntPronta); end
    checks++; if ({SaiValida, ULAOp, Dado1, Dado2} !== {1'b1, 2'b01, 8'd5, 8'd6}) begin errors++;
      $display("FAIL b2b_hold got=%b/%b/%0d/%0d exp=1/01/5/6", SaiValida, ULAOp, Dado1, Dado2); end
    tick();
    checks++; if ({SaiValida, Dado1, Dado2} !== {1'b1, 8'd5, 8'd6}) begin errors++;
      $display("FAIL b2b_stable got=%b/%0d/%0d exp=1/5/6", SaiValida, Dado1, Dado2); end
    SaiPronta = 1'b1;
    tick();
    checks++; if ({SaiValida, ULAOp, Dado1, Dado2, EntPronta} !== {1'b1, 2'b10, 8'd7, 8'd8, 1'b1}) begin errors++;
      $display("FAIL b2b_second got=%b/%b/%0d/%0d/%b exp=1/10/7/8/1", SaiValida, ULAOp, Dado1, Dado2, EntPronta); end
    tick();
    checks++; if (SaiValida !== 1'b0) begin errors++; $display("FAIL b2b_nodup got=%b exp=0", SaiValida); end
  endtask

  task automatic test_forwarding();
    SaiPronta = 1'b0;
    drive(2'b00, 2'd2, 2'd3, 8'h10, 8'h22, 1'b0, 8'h00);
    EscWB = 1'b1; RegWB = 2'd2; DadoWB = 8'h7F;
    tick();
    EntValida = 1'b0; EscWB = 1'b0;
    checks++; if ({Dado1, Dado2} !== {8'h7F, 8'h22}) begin errors++; $display("FAIL fwd_capture got=%h/%h exp=7f/22", Dado1, Dado2); end
    EscWB = 1'b1; RegWB = 2'd3; DadoWB = 8'hAA;
    tick();
    EscWB = 1'b0;
    checks++; if ({SaiValida, Dado1, Dado2} !== {1'b1, 8'h7F, 8'hAA}) begin errors++;
      $display("FAIL fwd_held got=%b/%h/%h exp=1/7f/aa", SaiValida, Dado1, Dado2); end
    SaiPronta = 1'b1;
    tick();
    SaiPronta = 1'b0;
    drive(2'b00, 2'd0, 2'd1, 8'h01, 8'h02, 1'b1, 8'h55);
    tick();
    EntValida = 1'b0;
    checks++; if ({Dado1, Dado2} !== {8'h01, 8'h55}) begin errors++; $display("FAIL imm_capture got=%h/%h exp=01/55", Dado1, Dado2); end
    EscWB = 1'b1; RegWB = 2'd1; DadoWB = 8'hAA;
    tick();
    EscWB = 1'b0;
    checks++; if ({Dado1, Dado2} !== {8'h01, 8'h55}) begin errors++; $display("FAIL imm_held got=%h/%h exp=01/55", Dado1, Dado2); end
    drive(2'b01, 2'd2, 2'd0, 8'h30, 8'h40, 1'b0, 8'h00);
    tick();
    EntValida = 1'b0;
    EscWB = 1'b1; RegWB = 2'd2; DadoWB = 8'h99;
    tick();
    EscWB = 1'b0; SaiPronta = 1'b1;
    tick();
    checks++; if ({SaiValida, ULAOp, Dado1, Dado2} !== {1'b1, 2'b01, 8'h99, 8'h40}) begin errors++;
      $display("FAIL fwd_skid got=%b/%b/%h/%h exp=1/01/99/40", SaiValida, ULAOp, Dado1, Dado2); end
    tick();
    checks++; if (SaiValida !== 1'b0) begin errors++; $display("FAIL fwd_drain got=%b exp=0", SaiValida); end
  endtask

  task automatic test_flush();
    SaiPronta = 1'b0;
    drive(2'b00, 2'd0, 2'd1, 8'h11, 8'h12, 1'b0, 8'h00);
    tick();
    drive(2'b00, 2'd0, 2'd1, 8'h13, 8'h14, 1'b0, 8'h00);
    tick();
    checks++; if ({SaiValida, EntPronta} !== 2'b10) begin errors++; $display("FAIL flush_pre got=%b%b exp=10", SaiValida, EntPronta); end
    Flush = 1'b1;
    drive(2'b00, 2'd0, 2'd1, 8'h15, 8'h16, 1'b0, 8'h00);
    tick();
    Flush = 1'b0; EntValida = 1'b0;
    checks++; if ({SaiValida, EntPronta} !== 2'b01) begin errors++; $display("FAIL flush got=%b%b exp=01", SaiValida, EntPronta); end
    tick();
    checks++; if (SaiValida !== 1'b0) begin errors++; $display("FAIL flush_discard got=%b exp=0", SaiValida); end
  endtask

  task automatic test_opinvalida();
    SaiPronta = 1'b1;
    checks++; if (OpInvalida !== 1'b0) begin errors++; $display("FAIL opinv_pre got=%b exp=0", OpInvalida); end
    drive(2'b11, 2'd0, 2'd1, 8'h01, 8'h02, 1'b0, 8'h00);
    tick();
    EntValida = 1'b0;
    checks++; if ({SaiValida, ULAOp, Dado1, Dado2, OpInvalida} !== {1'b1, 2'b11, 8'h01, 8'h02, 1'b1}) begin errors++;
      $display("FAIL opinv_pass got=%b/%b/%h/%h/%b exp=1/11/01/02/1", SaiValida, ULAOp, Dado1, Dado2, OpInvalida); end
    tick();
    tick();
    checks++; if ({SaiValida, OpInvalida} !== 2'b01) begin errors++; $display("FAIL opinv_sticky got=%b%b exp=01", SaiValida, OpInvalida); end
    drive(2'b00, 2'd0, 2'd1, 8'h21, 8'h22, 1'b0, 8'h00);
    tick();
    EntValida = 1'b0;
    Reset = 1'b0;
    tick();
    checks++; if ({SaiValida, ULAOp, Dado1, Dado2, OpInvalida, EntPronta} !== 22'h0) begin errors++;
      $display("FAIL opinv_reset got=%b/%b/%h/%h/%b/%b exp=0/00/00/00/0/0", SaiValida, ULAOp, Dado1, Dado2, OpInvalida, EntPronta); end
    Reset = 1'b1;
  endtask

  initial begin
    Reset = 1'b0; EntValida = 1'b0; EntULAOp = 2'b00; EntRegA = 2'd0; EntRegB = 2'd0;
    EntDadoA = 8'h00; EntDadoB = 8'h00; EntImediato = 8'h00; EntUsaImed = 1'b0;
    EscWB = 1'b0; RegWB = 2'd0; DadoWB = 8'h00; Flush = 1'b0; SaiPronta = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_forwarding();
    test_flush();
    test_opinvalida();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
